// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder.
// Holds the FSM state encoding and the legal byte-lane masks.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_HL = 4'b0011;
    localparam logic [3:0] BE_HH = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Naturally aligned byte, halfword and word masks only.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3,
            BE_HL, BE_HH, BE_W: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-wide RAM built from four byte lanes.
// Per-lane write enables; registered read port with lane masking.
module byte_lane_ram #(
    parameter int DEPTH   = 1024,
    parameter     MEMFILE = "",
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [3:0]    rmask,
    input  logic          rclr,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    // Byte-lane writes; array contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register: updates only on a completing load, zeroes off-lanes.
    always_ff @(posedge clk) begin
        if (!reset || rclr) begin
            rdata <= 32'h0;
        end else if (re) begin
            for (int i = 0; i < 4; i++) begin
                rdata[8*i +: 8] <= rmask[i] ? mem[addr][i] : 8'h00;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage load/store responder with programmable wait states.
// Stalls the pipeline for LATENCY cycles per access, then pulses memDone.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter     MEMFILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [3:0]  byteEnable,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        stall,
    output logic        memDone,
    output logic        fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam bit ONE_CYC = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT =
        4'(LATENCY >= 2 ? LATENCY - 2 : 0);

    mem_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic        wr_q;

    logic        req;
    logic        in_idle;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [3:0]  cur_be;
    logic        cur_wr;
    logic        legal;
    logic        oor;
    logic        go_done;
    logic        ok;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic        ram_clr;
    logic        unused_addr;

    assign req     = MemReadM | MemWriteM;
    assign in_idle = (state == IDLE);

    // With a single-cycle latency the commit edge is the accept edge,
    // so the request must be taken straight from the inputs there.
    assign cur_addr = in_idle ? ALUResultM : addr_q;
    assign cur_data = in_idle ? WriteDataM : data_q;
    assign cur_be   = in_idle ? byteEnable : be_q;
    assign cur_wr   = in_idle ? MemWriteM  : wr_q;

    assign legal = be_legal(cur_be);
    assign oor   = (cur_addr[31:2] >= DEPTH_W);
    assign ok    = legal & ~oor;

    assign go_done = reset &
        ((in_idle & req & ONE_CYC) |
         ((state == WAIT) & (cnt == 4'd0)));

    assign ram_we  = (go_done & cur_wr & ok) ? cur_be : 4'b0000;
    assign ram_re  = go_done & ~cur_wr & ok;
    assign ram_clr = go_done & oor;

    assign stall = reset & ((in_idle & req) | (state == WAIT));

    assign unused_addr = ^cur_addr[1:0];

    byte_lane_ram #(
        .DEPTH   (DEPTH),
        .MEMFILE (MEMFILE)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (cur_addr[AW+1:2]),
        .we    (ram_we),
        .wdata (cur_data),
        .re    (ram_re),
        .rmask (cur_be),
        .rclr  (ram_clr),
        .rdata (ReadDataM)
    );

    // Access FSM: accept in IDLE, count wait states, complete in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            memDone <= 1'b0;
            fault   <= 1'b0;
        end else begin
            memDone <= go_done;
            fault   <= go_done & ~ok;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= ALUResultM;
                        data_q <= WriteDataM;
                        be_q   <= byteEnable;
                        wr_q   <= MemWriteM;
                        cnt    <= CNT_INIT;
                        state  <= ONE_CYC ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Two instances: LATENCY=2 and LATENCY=1, both DEPTH=64.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] addr, wd;
    logic [31:0] rdata;
    logic        stall, done, flt;

    logic        rd1, wr1;
    logic [3:0]  be1;
    logic [31:0] addr1, wd1;
    logic [31:0] rdata1;
    logic        stall1, done1, flt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(rd), .MemWriteM(wr),
        .byteEnable(be), .ALUResultM(addr),
        .WriteDataM(wd), .ReadDataM(rdata),
        .stall(stall), .memDone(done), .fault(flt)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .MemReadM(rd1), .MemWriteM(wr1),
        .byteEnable(be1), .ALUResultM(addr1),
        .WriteDataM(wd1), .ReadDataM(rdata1),
        .stall(stall1), .memDone(done1), .fault(flt1)
    );

    // Issue one access, hold it until memDone, report what was seen.
    task automatic do_access(
        input  int          which,
        input  logic        r,
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  m,
        output int          scnt,
        output int          dcyc,
        output logic        f,
        output logic [31:0] q
    );
        logic s, dn;
        @(posedge clk); #1;
        if (which == 0) begin
            rd = r; wr = w; addr = a; wd = d; be = m;
        end else begin
            rd1 = r; wr1 = w; addr1 = a; wd1 = d; be1 = m;
        end
        scnt = 0; dcyc = 0; f = 1'b0; q = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            s  = (which == 0) ? stall : stall1;
            dn = (which == 0) ? done : done1;
            if (s) scnt++;
            if (dn) begin
                dcyc = n;
                f = (which == 0) ? flt : flt1;
                q = (which == 0) ? rdata : rdata1;
                break;
            end
        end
        vectors++;
        if (dcyc == 0) begin
            miscompares++;
            $display("FAIL timeout: no memDone within 40 cycles");
        end
        @(posedge clk); #1;
        rd = 0; wr = 0; rd1 = 0; wr1 = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 4;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall got %b want 0", stall);
        end
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", done);
        end
        if (flt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fault got %b want 0", flt);
        end
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        int sc, dc; logic f; logic [31:0] q;
        do_access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, sc, dc, f, q);
        vectors += 3;
        if (sc !== 2) begin
            miscompares++;
            $display("FAIL st_stall got %0d want 2", sc);
        end
        if (dc !== 3) begin
            miscompares++;
            $display("FAIL st_done_cycle got %0d want 3", dc);
        end
        if (f !== 1'b0) begin
            miscompares++;
            $display("FAIL st_fault got %b want 0", f);
        end
        do_access(0, 1, 0, 32'h10, 32'h0, 4'hF, sc, dc, f, q);
        vectors++;
        if (q !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL ld_data got %h want deadbeef", q);
        end
    endtask

    task automatic test_byte_store();
        int sc, dc; logic f; logic [31:0] q;
        do_access(0, 0, 1, 32'h20, 32'h11223344, 4'hF, sc, dc, f, q);
        do_access(0, 0, 1, 32'h20, 32'h00AA0000, 4'h4, sc, dc, f, q);
        do_access(0, 1, 0, 32'h20, 32'h0, 4'hF, sc, dc, f, q);
        vectors++;
        if (q !== 32'h11AA3344) begin
            miscompares++;
            $display("FAIL byte_merge got %h want 11aa3344", q);
        end
        do_access(0, 1, 0, 32'h22, 32'h0, 4'h3, sc, dc, f, q);
        vectors++;
        if (q !== 32'h00003344) begin
            miscompares++;
            $display("FAIL half_mask got %h want 00003344", q);
        end
    endtask

    task automatic test_illegal();
        int sc, dc; logic f; logic [31:0] q;
        do_access(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h5, sc, dc, f, q);
        vectors += 3;
        if (f !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_mask_fault got %b want 1", f);
        end
        if (sc !== 2) begin
            miscompares++;
            $display("FAIL bad_mask_wait got %0d want 2", sc);
        end
        if (q !== 32'h00003344) begin
            miscompares++;
            $display("FAIL bad_mask_rdata got %h want 00003344", q);
        end
        do_access(0, 1, 0, 32'h20, 32'h0, 4'hF, sc, dc, f, q);
        vectors += 2;
        if (q !== 32'h11AA3344) begin
            miscompares++;
            $display("FAIL bad_mask_nowrite got %h want 11aa3344", q);
        end
        if (f !== 1'b0) begin
            miscompares++;
            $display("FAIL good_fault got %b want 0", f);
        end
        do_access(0, 1, 0, 32'h100, 32'h0, 4'hF, sc, dc, f, q);
        vectors += 2;
        if (f !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_fault got %b want 1", f);
        end
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_rdata got %h want 0", q);
        end
    endtask

    task automatic test_stale();
        logic [5:0] sp, dp;
        @(posedge clk); #1;
        rd = 1; wr = 0; addr = 32'h10; be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sp[5-i] = stall;
            dp[5-i] = done;
        end
        @(posedge clk); #1;
        rd = 0;
        @(posedge clk); #1;
        vectors += 3;
        if (sp !== 6'b110110) begin
            miscompares++;
            $display("FAIL stale_stall got %b want 110110", sp);
        end
        if (dp !== 6'b001001) begin
            miscompares++;
            $display("FAIL stale_done got %b want 001001", dp);
        end
        if (rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL stale_rdata got %h want deadbeef", rdata);
        end
    endtask

    task automatic test_reset_mid();
        int sc, dc; logic f; logic [31:0] q;
        @(posedge clk); #1;
        wr = 1; addr = 32'h10; wd = 32'h12345678; be = 4'hF;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_accept got %b want 1", stall);
        end
        @(posedge clk); #1;
        reset = 1'b0; wr = 0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors += 3;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stall got %b want 0", stall);
        end
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_done got %b want 0", done);
        end
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_rdata got %h want 0", rdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_access(0, 1, 0, 32'h10, 32'h0, 4'hF, sc, dc, f, q);
        vectors += 2;
        if (q !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rst_nowrite got %h want deadbeef", q);
        end
        if (sc !== 2) begin
            miscompares++;
            $display("FAIL rst_idle got %0d want 2", sc);
        end
    endtask

    task automatic test_lat1();
        int sc, dc; logic f; logic [31:0] q;
        do_access(1, 0, 1, 32'h40, 32'hCAFEF00D, 4'hF, sc, dc, f, q);
        do_access(1, 1, 0, 32'h40, 32'h0, 4'hF, sc, dc, f, q);
        vectors += 3;
        if (sc !== 1) begin
            miscompares++;
            $display("FAIL l1_stall got %0d want 1", sc);
        end
        if (dc !== 2) begin
            miscompares++;
            $display("FAIL l1_done_cycle got %0d want 2", dc);
        end
        if (q !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL l1_load got %h want cafef00d", q);
        end
        do_access(1, 1, 1, 32'h40, 32'h0BADBEEF, 4'hF, sc, dc, f, q);
        vectors++;
        if (q !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL l1_rw_rdata got %h want cafef00d", q);
        end
        do_access(1, 1, 0, 32'h40, 32'h0, 4'hF, sc, dc, f, q);
        vectors++;
        if (q !== 32'h0BADBEEF) begin
            miscompares++;
            $display("FAIL l1_rw_write got %h want 0badbeef", q);
        end
    endtask

    initial begin
        rd = 0; wr = 0; be = 0; addr = 0; wd = 0;
        rd1 = 0; wr1 = 0; be1 = 0; addr1 = 0; wd1 = 0;
        test_reset();
        test_store_load();
        test_byte_store();
        test_illegal();
        test_stale();
        test_reset_mid();
        test_lat1();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
